uart_rx_fifo: RTL
=================

# uart_rx_fifo

UART receive front-end for the RISC-V platform: samples the asynchronous `rx` pin, deserialises 8N1 frames and buffers received bytes in a small FIFO. It sits between the board pin and the UART peripheral's receive-data register. That register pops bytes on a CPU load through the memory map, and sees status flags (empty, full, overrun, framing error) for polling.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per bit (50 MHz / 115200); must be ≥ 4; `HALF` = `CLKS_PER_BIT/2` (floor)
- `FIFO_DEPTH`, 8, byte entries; power of two, ≥ 2
- `clk`  in  1  single system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `rx`  in  1  serial input, asynchronous to `clk`, idle high
- `rd_en`  in  1  pop head entry this cycle
- `clr_err`  in  1  one-cycle pulse, clears sticky error flags
- `rd_data`  out  8  head entry (show-ahead); 8'h00 when empty
- `empty`  out  1  FIFO holds no bytes
- `full`  out  1  FIFO holds `FIFO_DEPTH` bytes
- `count`  out  $clog2(FIFO_DEPTH)+1  bytes held
- `overrun`  out  1  sticky: byte dropped because FIFO full
- `frame_err`  out  1  sticky: stop bit sampled low
- `rx_busy`  out  1  receiver FSM not in IDLE

## Operation
- `rx` passes through a 2-flop synchroniser (`rx_s`); both flops reset to 1.
- Bits arrive LSB first. A shift register collects them. A bit counter runs 0..7. A cycle counter `cnt` runs 0..`CLKS_PER_BIT-1` and is cleared on every state change.
- FSM states:
  - IDLE: `rx_s`=0 → START, `cnt`=0.
  - START: at `cnt`==`HALF-1`, if `rx_s`=0 → DATA; otherwise → IDLE (glitch rejected, nothing pushed, no flag set).
  - DATA: at `cnt`==`CLKS_PER_BIT-1`, shift in `rx_s`. After the 8th bit → STOP.
  - STOP: at `cnt`==`CLKS_PER_BIT-1`, sample `rx_s`:
    - 1, FIFO not full (or popped same cycle) → push byte, → IDLE.
    - 1, FIFO full, no pop → drop byte, set `overrun`, → IDLE.
    - 0 → discard byte, set `frame_err`, → BREAK.
  - BREAK: wait for `rx_s`=1 → IDLE. This prevents a held-low line from being decoded as repeated frames.
- FIFO:
  - Circular buffer with read/write pointers of $clog2(FIFO_DEPTH)+1 bits; the MSB is the wrap bit.
  - `empty` = pointers equal. `full` = indices equal and wrap bits differ.
  - `rd_en` while empty is ignored; pointers and `count` are unchanged.
  - Push and pop in the same cycle: both take effect and `count` is unchanged. If full, the pop frees the slot and no overrun is flagged.
  - `rd_data` is combinational from the head entry and reads 8'h00 when empty.
- Errors:
  - `clr_err` clears both sticky flags.
  - If an error is set in the same cycle as `clr_err`, set wins.
- Reset mid-frame: FSM → IDLE, FIFO emptied, partial byte lost.

## Timing
- Reset values:
  - `empty`=1, `full`=0, `count`=0, `rd_data`=8'h00.
  - `overrun`=0, `frame_err`=0, `rx_busy`=0.
  - FSM IDLE, pointers 0.
- Let edge E0 be the first `clk` edge at which the first synchroniser flop captures `rx`=0.
  - E0+2: IDLE→START.
  - E0+2+`HALF`: START→DATA.
  - E0+2+`HALF`+8·`CLKS_PER_BIT`: DATA→STOP.
  - E0+2+`HALF`+9·`CLKS_PER_BIT`: push; `empty`, `count` and `rd_data` update after this edge.
- Each data bit is sampled `HALF`+k·`CLKS_PER_BIT` cycles after START entry, i.e. at mid-bit.
- Pop: `rd_data`, `count`, `empty` and `full` reflect the pop after the edge at which `rd_en`=1.
- Back-to-back frames: a start bit immediately following the stop bit is detected. IDLE checks `rx_s` on the edge after returning, so throughput is 1 byte per 10 bit times.
- All outputs are registered except `rd_data`, which is decoded from registered storage.

## Test plan
Run all scenarios with `CLKS_PER_BIT`=16 and `FIFO_DEPTH`=4.
- Single frame 8'hA5, no pop → at E0+2+8+144, `empty` 1→0, `rd_data`=8'hA5, `count`=1. Pulse `rd_en` → `empty`=1, `rd_data`=8'h00.
- 5 back-to-back frames 8'h01..8'h05, no pops → `full`=1 after the 4th byte. The 5th byte is dropped and `overrun`=1. Pops return 01,02,03,04. `clr_err` → `overrun`=0.
- Frame with stop bit=0, then `rx` held low for 40 cycles → `frame_err`=1, FIFO unchanged, `rx_busy`=1 until `rx` returns high. No further frames are decoded. A following frame 8'h3C is then received correctly.
- 4-cycle low glitch on idle `rx` → FSM returns to IDLE, `empty` stays 1, no flags set.
- FIFO full; 5th frame's push edge coincides with `rd_en`=1 → `overrun`=0, `count` stays 4. Read order is 2nd..5th byte.
- Assert `rst` mid-DATA with 2 bytes queued → all outputs take reset values immediately. A subsequent frame 8'h7E is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// Receive-side bus of the UART front-end: serial pin, pop/clear controls and FIFO status.
// The master modport is the consumer (peripheral register / bench), the slave modport is the receiver.
interface uart_rx_fifo_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             rx;
  logic             rd_en;
  logic             clr_err;
  logic [7:0]       rd_data;
  logic             empty;
  logic             full;
  logic [CNT_W-1:0] count;
  logic             overrun;
  logic             frame_err;
  logic             rx_busy;

  modport master (
    output rx, rd_en, clr_err,
    input  rd_data, empty, full, count, overrun, frame_err, rx_busy
  );

  modport slave (
    input  rx, rd_en, clr_err,
    output rd_data, empty, full, count, overrun, frame_err, rx_busy
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a show-ahead byte FIFO and sticky overrun/framing-error flags.
// Bits are sampled mid-bit, timed from the half-bit start-bit check.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_fifo_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_BREAK
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          rx_meta_q, rx_s_q;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_q, count_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          ovr_q, ovr_d;
  logic          ferr_q, ferr_d;
  logic          busy_q, busy_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic          stop_done, pop, push, set_ovr, set_ferr;

  // Both synchroniser flops reset high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ovr_q    <= 1'b0;
      ferr_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ovr_q    <= ovr_d;
      ferr_q   <= ferr_d;
      busy_q   <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = rx_s_q ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // A pop in the same cycle frees the slot, so a full FIFO can still accept the byte.
  always_comb begin
    stop_done = (state_q == S_STOP) && (cnt_q == LAST);
    pop       = bus.rd_en && !empty_q;
    push      = stop_done && rx_s_q && (!full_q || pop);
    set_ovr   = stop_done && rx_s_q && full_q && !pop;
    set_ferr  = stop_done && !rx_s_q;

    wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d   = wr_ptr_d - rd_ptr_d;
    empty_d   = (wr_ptr_d == rd_ptr_d);
    full_d    = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]);

    ovr_d     = set_ovr  || (ovr_q  && !bus.clr_err);
    ferr_d    = set_ferr || (ferr_q && !bus.clr_err);
    busy_d    = (state_d != S_IDLE);
  end

  assign bus.rd_data   = empty_q ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
  assign bus.empty     = empty_q;
  assign bus.full      = full_q;
  assign bus.count     = count_q;
  assign bus.overrun   = ovr_q;
  assign bus.frame_err = ferr_q;
  assign bus.rx_busy   = busy_q;
endmodule
